// File: rtl/apb_master.sv
// ============================================================================
//  Module   : apb_master
//  Purpose  : Single-channel APB requester. Turns a valid/ready command into
//             one APB SETUP/ACCESS transfer and returns the result on a
//             one-cycle response strobe (read data, or a timeout error).
//  Ports    : pclk, preset           - clock, synchronous active-high reset
//             cmd_valid/cmd_ready    - command handshake (ready only in IDLE)
//             cmd_write/addr/wdata   - command payload, sampled on accept
//             rsp_valid/rdata/err    - response strobe, read data, timeout
//             psel1/penable/pwrite/paddr/pwdata - registered APB outputs
//             pready/prdata          - APB slave response
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_master #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16    // legal range 2..255
) (
  input  logic              pclk,
  input  logic              preset,
  // command side
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  // response side
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  // APB side
  output logic              psel1,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic              pready,
  input  logic [DATA_W-1:0] prdata
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  localparam int              CNT_W    = 8;
  // Counter value of the last ACCESS cycle in which pready may still arrive.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                psel_q;
  logic                penable_q;
  logic                pwrite_q;
  logic [ADDR_W-1:0]   paddr_q;
  logic [DATA_W-1:0]   pwdata_q;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic                rsp_err_q;

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      // The response is a single-cycle strobe; it falls unless re-asserted below.
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;

      case (state_q)
        S_IDLE: begin
          penable_q <= 1'b0;
          if (cmd_valid) begin
            pwrite_q <= cmd_write;
            paddr_q  <= cmd_addr;
            pwdata_q <= cmd_wdata;
            psel_q   <= 1'b1;
            state_q  <= S_SETUP;
          end else begin
            psel_q   <= 1'b0;
          end
        end

        S_SETUP: begin
          // pready is not looked at here: a slave still holding pready from
          // the previous transfer must not complete this one early.
          penable_q <= 1'b1;
          cnt_q     <= '0;
          state_q   <= S_ACCESS;
        end

        S_ACCESS: begin
          // Completion is tested first so that pready in the final allowed
          // cycle wins over the timeout.
          if (pready) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= pwrite_q ? '0 : prdata;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            state_q     <= S_IDLE;
          end else if (cnt_q == CNT_LAST) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            state_q     <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        default: begin
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = (state_q == S_IDLE);

  assign psel1     = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

`default_nettype wire

// File: tb/tb_apb_master.sv
// ============================================================================
//  Module   : tb_apb_master
//  Purpose  : Directed self-checking bench for apb_master with a small
//             memory slave that answers with a registered pready, plus an
//             override so pready/prdata can be forced cycle by cycle.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_master;

  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 16;

  logic              pclk = 1'b0;
  logic              preset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              psel1;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic              pready;
  logic [DATA_W-1:0] prdata;

  always #5 pclk = ~pclk;

  apb_master #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) u_dut (
    .pclk     (pclk),
    .preset   (preset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .psel1    (psel1),
    .penable  (penable),
    .pwrite   (pwrite),
    .paddr    (paddr),
    .pwdata   (pwdata),
    .pready   (pready),
    .prdata   (prdata)
  );

  // Memory slave: pready follows psel&penable one cycle later, so it stays
  // high for one cycle after each transfer.
  logic              slv_pready_q;
  logic [DATA_W-1:0] mem [256];
  logic              force_en;
  logic              force_val;
  logic [DATA_W-1:0] force_data;

  initial for (int i = 0; i < 256; i++) mem[i] = '0;

  always @(posedge pclk) begin
    if (preset) slv_pready_q <= 1'b0;
    else        slv_pready_q <= psel1 & penable;
    if (!preset && psel1 && penable && pready && pwrite) mem[paddr] <= pwdata;
  end

  assign pready = force_en ? force_val  : slv_pready_q;
  assign prdata = force_en ? force_data : mem[paddr];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge pclk);
    #1;
  endtask

  // One command; lat counts edges since acceptance (lat=1 is SETUP, the
  // response normally shows up at lat=4). mask[lat] is the forced pready
  // value for cycle lat when force_en is set.
  task automatic xfer(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                      input logic [63:0] mask,
                      output logic [7:0] rdata, output logic err, output int lat);
    lat = 0; rdata = '0; err = 1'b0;
    check("cmd_ready before issue", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
    force_val = mask[0];
    tick; lat = 1;
    // Scramble the payload: the transfer must use the values from the accept edge.
    cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = ~addr; cmd_wdata = ~wdata;
    while (!rsp_valid && lat < 40) begin
      force_val = mask[lat];
      check("busy psel1", psel1, 1);
      check("busy penable", penable, (lat >= 2) ? 1 : 0);
      check("busy cmd_ready", cmd_ready, 0);
      check("busy paddr", paddr, addr);
      check("busy pwrite", pwrite, wr);
      if (wr) check("busy pwdata", pwdata, wdata);
      tick; lat++;
    end
    force_val = 1'b0;
    check("rsp_valid seen", rsp_valid, 1);
    rdata = rsp_rdata;
    err   = rsp_err;
    check("rsp cycle psel1", psel1, 0);
    check("rsp cycle penable", penable, 0);
    tick;
    check("rsp_valid one cycle", rsp_valid, 0);
  endtask

  logic [7:0] rd;
  logic       er;
  int         lat;

  logic       b_wr   [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [7:0] b_addr [6] = '{8'h00, 8'h01, 8'h02, 8'h00, 8'h01, 8'h02};
  logic [7:0] b_data [6] = '{8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00};
  logic [7:0] b_exp  [6] = '{8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33};

  initial begin
    force_en = 1'b0; force_val = 1'b0; force_data = '0;
    preset = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h55; cmd_wdata = 8'hAA;

    // Reset with a pending command: nothing may leave the block.
    for (int i = 0; i < 3; i++) begin
      tick;
      check("reset outputs", {psel1, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err}, 0);
    end
    cmd_valid = 1'b0;
    preset    = 1'b0;
    tick;
    check("post-reset cmd_ready", cmd_ready, 1);
    check("post-reset outputs", {psel1, penable, rsp_valid, rsp_err}, 0);

    // Write then read against the memory slave.
    xfer(1'b1, 8'h3C, 8'hA5, 64'd0, rd, er, lat);
    check("wr err", er, 0);
    check("wr rdata zero", rd, 0);
    check("wr latency", lat, 4);
    xfer(1'b0, 8'h3C, 8'h00, 64'd0, rd, er, lat);
    check("rd err", er, 0);
    check("rd data", rd, 8'hA5);
    check("rd latency", lat, 4);

    // Back-to-back: cmd_valid held high across six commands.
    begin
      int idx, nrsp, last_acc;
      logic acc;
      idx = 0; nrsp = 0; last_acc = -1;
      cmd_valid = 1'b1; cmd_write = b_wr[0]; cmd_addr = b_addr[0]; cmd_wdata = b_data[0];
      for (int c = 0; c < 40; c++) begin
        acc = cmd_valid & cmd_ready;
        if (psel1) check("b2b cmd_ready low while busy", cmd_ready, 0);
        tick;
        if (rsp_valid) begin
          check("b2b rsp_err", rsp_err, 0);
          if (nrsp < 6) check("b2b rsp_rdata", rsp_rdata, b_exp[nrsp]);
          check("b2b psel1 gap", psel1, 0);
          nrsp++;
        end
        if (acc) begin
          if (last_acc >= 0) check("b2b accept spacing", c - last_acc, 4);
          last_acc = c;
          idx++;
          if (idx < 6) begin
            cmd_write = b_wr[idx]; cmd_addr = b_addr[idx]; cmd_wdata = b_data[idx];
          end else begin
            cmd_valid = 1'b0;
          end
        end
      end
      check("b2b response count", nrsp, 6);
    end
    tick;

    // Timeout: pready held low, 16 ACCESS cycles (lat 2..17), abort at lat 18.
    force_en = 1'b1; force_data = 8'hEE;
    xfer(1'b0, 8'h80, 8'h00, 64'd0, rd, er, lat);
    check("tmo err", er, 1);
    check("tmo rdata", rd, 0);
    check("tmo latency", lat, 18);
    check("tmo after psel/penable", {psel1, penable}, 0);
    check("tmo after cmd_ready", cmd_ready, 1);

    // pready in the last allowed ACCESS cycle: completion, not timeout.
    force_data = 8'h5A;
    xfer(1'b0, 8'h81, 8'h00, 64'd1 << 17, rd, er, lat);
    check("edge err", er, 0);
    check("edge rdata", rd, 8'h5A);
    check("edge latency", lat, 18);

    // Stray pready during SETUP is ignored; real pready in cycle 4.
    force_data = 8'h77;
    xfer(1'b0, 8'h82, 8'h00, (64'd1 << 1) | (64'd1 << 4), rd, er, lat);
    check("stray err", er, 0);
    check("stray rdata", rd, 8'h77);
    check("stray latency", lat, 5);

    // Reset during the second ACCESS cycle of a read.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h40; force_val = 1'b0;
    tick;                 // SETUP
    cmd_valid = 1'b0;
    tick;                 // ACCESS 1
    tick;                 // ACCESS 2
    check("pre-reset penable", penable, 1);
    preset = 1'b1;
    tick;
    check("midrst psel1/penable", {psel1, penable}, 0);
    check("midrst rsp_valid", rsp_valid, 0);
    preset   = 1'b0;
    force_en = 1'b0;
    tick;
    check("midrst rsp_valid after", rsp_valid, 0);
    check("midrst cmd_ready", cmd_ready, 1);
    xfer(1'b1, 8'hFF, 8'hC3, 64'd0, rd, er, lat);
    check("midrst wr err", er, 0);
    xfer(1'b0, 8'hFF, 8'h00, 64'd0, rd, er, lat);
    check("midrst rd err", er, 0);
    check("midrst rd data", rd, 8'hC3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
